// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback unit.
// This block is the only writer of the register-file write port. It retires one
// instruction per accept. Loads park the stage in WAIT until mem_rvalid arrives.
// The returned word is then aligned and extended per load opcode.
module wb_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [4:0]       in_reg_dst_id,
  input  logic [31:0]      in_alu_result,
  input  logic             in_mem_to_reg,
  input  logic [2:0]       in_load_op,
  input  logic [31:0]      in_rt_value,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             reg_write,
  output logic [4:0]       reg_write_id,
  output logic [31:0]      reg_write_data,
  output logic             wb_stall,
  output logic             protocol_err,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t             state_reg, state_next;
  logic               reg_write_reg, reg_write_next;
  logic [4:0]         wr_id_reg, wr_id_next;
  logic [31:0]        wr_data_reg, wr_data_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        wait_reg, wait_next;
  logic [4:0]         ld_dst_reg, ld_dst_next;
  logic               ld_wr_reg, ld_wr_next;
  logic [2:0]         ld_op_reg, ld_op_next;
  logic [1:0]         ld_k_reg, ld_k_next;
  logic [31:0]        ld_rt_reg, ld_rt_next;

  // Align/extend the returned word; k is the byte offset within the word.
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] k,
                                          input logic [31:0] w, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {k, 3'b000});
    h = k[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      3'b010: begin
        // lwl: high bytes from memory, low bytes kept from rt
        case (k)
          2'd0:    r = {w[7:0],  rt[23:0]};
          2'd1:    r = {w[15:0], rt[15:0]};
          2'd2:    r = {w[23:0], rt[7:0]};
          default: r = w;
        endcase
      end
      3'b110: begin
        // lwr: low bytes from memory, high bytes kept from rt
        case (k)
          2'd0:    r = w;
          2'd1:    r = {rt[31:24], w[31:8]};
          2'd2:    r = {rt[31:16], w[31:16]};
          default: r = {rt[31:8],  w[31:24]};
        endcase
      end
      default: r = w;
    endcase
    return r;
  endfunction

  assign in_ready       = (state_reg == IDLE);
  assign wb_stall       = (state_reg == WAIT);
  assign reg_write      = reg_write_reg;
  assign reg_write_id   = wr_id_reg;
  assign reg_write_data = wr_data_reg;
  assign protocol_err   = err_reg;
  assign retire_count   = cnt_reg;

  // Next-state, writeback and load-context logic.
  always_comb begin
    state_next     = state_reg;
    reg_write_next = 1'b0;
    wr_id_next     = wr_id_reg;
    wr_data_next   = wr_data_reg;
    err_next       = err_reg;
    cnt_next       = cnt_reg;
    wait_next      = wait_reg;
    ld_dst_next    = ld_dst_reg;
    ld_wr_next     = ld_wr_reg;
    ld_op_next     = ld_op_reg;
    ld_k_next      = ld_k_reg;
    ld_rt_next     = ld_rt_reg;
    case (state_reg)
      IDLE: begin
        // Any rvalid here has no load to belong to.
        if (mem_rvalid) err_next = 1'b1;
        if (in_valid) begin
          if (in_mem_to_reg) begin
            ld_dst_next = in_reg_dst_id;
            ld_wr_next  = in_reg_write;
            ld_op_next  = in_load_op;
            ld_k_next   = in_alu_result[1:0];
            ld_rt_next  = in_rt_value;
            wait_next   = 16'h0;
            state_next  = WAIT;
          end else begin
            reg_write_next = in_reg_write && (in_reg_dst_id != 5'd0);
            wr_id_next     = in_reg_dst_id;
            wr_data_next   = in_alu_result;
            cnt_next       = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        if (mem_rvalid) begin
          reg_write_next = ld_wr_reg && (ld_dst_reg != 5'd0);
          wr_id_next     = ld_dst_reg;
          wr_data_next   = extract(ld_op_reg, ld_k_reg, mem_rdata, ld_rt_reg);
          cnt_next       = cnt_reg + 1'b1;
          state_next     = IDLE;
        end else begin
          // Saturating count; flag once the limit is reached, keep waiting.
          if (wait_reg != 16'hFFFF) wait_next = wait_reg + 16'd1;
          if (wait_next >= TIMEOUT) err_next = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      reg_write_reg <= 1'b0;
      wr_id_reg     <= 5'd0;
      wr_data_reg   <= 32'd0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      wait_reg      <= 16'h0;
      ld_dst_reg    <= 5'd0;
      ld_wr_reg     <= 1'b0;
      ld_op_reg     <= 3'd0;
      ld_k_reg      <= 2'd0;
      ld_rt_reg     <= 32'd0;
    end else begin
      state_reg     <= state_next;
      reg_write_reg <= reg_write_next;
      wr_id_reg     <= wr_id_next;
      wr_data_reg   <= wr_data_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
      wait_reg      <= wait_next;
      ld_dst_reg    <= ld_dst_next;
      ld_wr_reg     <= ld_wr_next;
      ld_op_reg     <= ld_op_next;
      ld_k_reg      <= ld_k_next;
      ld_rt_reg     <= ld_rt_next;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writeback, load extraction, r0 suppression,
// timeout, async reset, stray rvalid and back-to-back retirement with count wrap.
module tb_wb_stage;
  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_reg_write, in_mem_to_reg;
  logic [4:0]  in_reg_dst_id;
  logic [31:0] in_alu_result, in_rt_value;
  logic [2:0]  in_load_op;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  reg_write_id;
  logic [31:0] reg_write_data;
  logic        wb_stall, protocol_err;
  logic [3:0]  retire_count;

  int total = 0;
  int bad   = 0;
  logic [3:0]  exp_cnt;
  logic [31:0] last_data;

  wb_stage #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
    .in_reg_dst_id(in_reg_dst_id), .in_alu_result(in_alu_result),
    .in_mem_to_reg(in_mem_to_reg), .in_load_op(in_load_op), .in_rt_value(in_rt_value),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_write(reg_write), .reg_write_id(reg_write_id), .reg_write_data(reg_write_data),
    .wb_stall(wb_stall), .protocol_err(protocol_err), .retire_count(retire_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_reg_write = 0; in_reg_dst_id = 0; in_alu_result = 0;
    in_mem_to_reg = 0; in_load_op = 0; in_rt_value = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    exp_cnt = 0;
  endtask

  // Issue a load, keep WAIT for nwait cycles, then return w. Junk is driven on
  // in_* during WAIT and must be ignored.
  task automatic do_load(input string name, input logic [2:0] op, input logic [1:0] k,
                         input logic [31:0] rt, input logic [31:0] w, input logic [4:0] dst,
                         input logic wf, input logic exp_we, input logic [31:0] exp_data);
    int stalls;
    stalls = 0;
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = wf; in_reg_dst_id = dst;
    in_alu_result = {30'h1000, k}; in_load_op = op; in_rt_value = rt;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s ready_before_accept got=%b want=1", name, in_ready); end
    step();
    in_mem_to_reg = 0; in_reg_write = 1; in_reg_dst_id = 5'd9; in_alu_result = 32'hDEAD_BEEF;
    total++;
    if (reg_write !== 1'b0) begin bad++; $display("FAIL %s we_after_accept got=%b want=0", name, reg_write); end
    for (int i = 0; i < 3; i++) begin
      if (wb_stall === 1'b1) stalls++;
      step();
    end
    mem_rvalid = 1; mem_rdata = w;
    if (wb_stall === 1'b1) stalls++;
    step();
    mem_rvalid = 0; in_valid = 0;
    exp_cnt = exp_cnt + 4'd1;
    total++;
    if (stalls != 4) begin bad++; $display("FAIL %s stall_cycles got=%0d want=4", name, stalls); end
    total++;
    if (reg_write !== exp_we) begin bad++; $display("FAIL %s we got=%b want=%b", name, reg_write, exp_we); end
    total++;
    if (reg_write_data !== exp_data || reg_write_id !== dst)
      begin bad++; $display("FAIL %s data got=%h/%0d want=%h/%0d", name, reg_write_data, reg_write_id, exp_data, dst); end
    total++;
    if (retire_count !== exp_cnt || in_ready !== 1'b1 || wb_stall !== 1'b0)
      begin bad++; $display("FAIL %s cnt/ready got=%0d/%b/%b want=%0d/1/0", name, retire_count, in_ready, wb_stall, exp_cnt); end
    step();
    total++;
    if (reg_write !== 1'b0 || retire_count !== exp_cnt)
      begin bad++; $display("FAIL %s junk_ignored got=%b/%0d want=0/%0d", name, reg_write, retire_count, exp_cnt); end
    last_data = exp_data;
    $display("load %s op=%0d k=%0d data=%h", name, op, k, reg_write_data);
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (reg_write !== 0 || reg_write_id !== 0 || reg_write_data !== 0 || protocol_err !== 0 ||
        retire_count !== 0 || in_ready !== 1 || wb_stall !== 0)
      begin bad++; $display("FAIL reset_state got=%b/%0d/%h/%b/%0d/%b/%b", reg_write, reg_write_id,
                            reg_write_data, protocol_err, retire_count, in_ready, wb_stall); end
    $display("reset checked");
  endtask

  task automatic test_alu();
    in_valid = 1; in_mem_to_reg = 0; in_reg_write = 1; in_reg_dst_id = 5; in_alu_result = 32'h1234;
    step();
    in_valid = 0;
    exp_cnt = exp_cnt + 4'd1;
    total++;
    if (reg_write !== 1 || reg_write_id !== 5 || reg_write_data !== 32'h1234 || retire_count !== exp_cnt)
      begin bad++; $display("FAIL alu_write got=%b/%0d/%h/%0d want=1/5/00001234/%0d",
                            reg_write, reg_write_id, reg_write_data, retire_count, exp_cnt); end
    step();
    total++;
    if (reg_write !== 0 || reg_write_data !== 32'h1234)
      begin bad++; $display("FAIL alu_pulse got=%b/%h want=0/00001234", reg_write, reg_write_data); end
    last_data = 32'h1234;
    $display("alu addu r5 data=%h", reg_write_data);
  endtask

  task automatic test_loads();
    do_load("lb",  3'b000, 2'd1, 32'h0, 32'h1122_80FF, 5'd3, 1, 1, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 2'd1, 32'h0, 32'h1122_80FF, 5'd3, 1, 1, 32'h0000_0080);
    do_load("lwl", 3'b010, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd7, 1, 1, 32'h3344_CCDD);
    do_load("lwr", 3'b110, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 5'd8, 1, 1, 32'hAABB_1122);
    do_load("lh",  3'b001, 2'd3, 32'h0, 32'h9ABC_1234, 5'd4, 1, 1, 32'hFFFF_9ABC);
    do_load("lw",  3'b011, 2'd0, 32'h0, 32'hCAFE_F00D, 5'd6, 1, 1, 32'hCAFE_F00D);
  endtask

  task automatic test_r0_load();
    logic [31:0] prev;
    prev = last_data;
    // Data/id still latch on retirement; only the enable is suppressed.
    do_load("r0", 3'b011, 2'd0, 32'h0, 32'h5555_AAAA, 5'd0, 1, 0, 32'h5555_AAAA);
    total++;
    if (prev === reg_write_data) begin bad++; $display("FAIL r0_data_latched got=%h", reg_write_data); end
  endtask

  task automatic test_timeout();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_reg_dst_id = 2; in_load_op = 3'b011;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (protocol_err !== 0 || wb_stall !== 1)
      begin bad++; $display("FAIL timeout_early got=%b/%b want=0/1", protocol_err, wb_stall); end
    step();
    total++;
    if (protocol_err !== 1 || wb_stall !== 1 || reg_write !== 0)
      begin bad++; $display("FAIL timeout_set got=%b/%b/%b want=1/1/0", protocol_err, wb_stall, reg_write); end
    step();
    total++;
    if (protocol_err !== 1 || wb_stall !== 1)
      begin bad++; $display("FAIL timeout_sticky got=%b/%b want=1/1", protocol_err, wb_stall); end
    rst_n = 0;
    #1;
    total++;
    if (protocol_err !== 0 || wb_stall !== 0 || in_ready !== 1 || reg_write_data !== 0 ||
        reg_write_id !== 0 || retire_count !== 0)
      begin bad++; $display("FAIL async_reset got=%b/%b/%b/%h/%0d/%0d", protocol_err, wb_stall,
                            in_ready, reg_write_data, reg_write_id, retire_count); end
    #2;
    rst_n = 1;
    exp_cnt = 0;
    step();
    $display("timeout err=%b after reset stall=%b", protocol_err, wb_stall);
  endtask

  task automatic test_stray_and_back_to_back();
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    step();
    mem_rvalid = 0;
    total++;
    if (protocol_err !== 1 || reg_write !== 0 || retire_count !== exp_cnt)
      begin bad++; $display("FAIL stray_rvalid got=%b/%b/%0d want=1/0/%0d", protocol_err, reg_write, retire_count, exp_cnt); end
    $display("stray rvalid err=%b", protocol_err);
    in_mem_to_reg = 0; in_reg_write = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_reg_dst_id = 5'(i + 1); in_alu_result = 32'h100 + i;
      step();
      exp_cnt = exp_cnt + 4'd1;
      total++;
      if (reg_write !== 1 || reg_write_id !== 5'(i + 1) || reg_write_data !== 32'h100 + i || retire_count !== exp_cnt)
        begin bad++; $display("FAIL b2b_%0d got=%b/%0d/%h/%0d want=1/%0d/%h/%0d", i, reg_write, reg_write_id,
                              reg_write_data, retire_count, i + 1, 32'h100 + i, exp_cnt); end
      $display("b2b %0d id=%0d data=%h cnt=%0d", i, reg_write_id, reg_write_data, retire_count);
    end
    in_valid = 0;
    step();
    total++;
    if (reg_write !== 0 || retire_count !== 4'd4)
      begin bad++; $display("FAIL b2b_end_wrap got=%b/%0d want=0/4", reg_write, retire_count); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    #2;
    test_reset();
    test_alu();
    test_loads();
    test_r0_load();
    test_timeout();
    test_stray_and_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the whole run regardless of DUT behaviour.
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
